// File: rtl/msg_tx_pkg.sv
// Shared types and constants for the message transmitter.
package msg_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_NEXT,
        ST_FINISH
    } state_t;

    localparam logic [7:0] CR_BYTE = 8'h0D;
    localparam logic [7:0] LF_BYTE = 8'h0A;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: LSB first, idle high, one character per send strobe.
module uart_tx #(
    parameter int CLOCKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt_reg;
    logic [3:0]       bits_left_reg;
    logic [8:0]       shift_reg;
    logic             busy_reg;
    logic             tx_reg;

    // Start bit goes out on the accepting edge; then 8 data bits and the stop
    // bit are shifted out, each held CLOCKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_reg   <= '0;
            bits_left_reg <= '0;
            shift_reg     <= '1;
            busy_reg      <= 1'b0;
            tx_reg        <= 1'b1;
        end else if (!busy_reg) begin
            if (send) begin
                busy_reg      <= 1'b1;
                tx_reg        <= 1'b0;
                shift_reg     <= {1'b1, data};
                bits_left_reg <= 4'd9;
                clk_cnt_reg   <= '0;
            end
        end else if (clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg <= '0;
            if (bits_left_reg == 4'd0) begin
                // End of stop bit; line is already high.
                busy_reg <= 1'b0;
            end else begin
                tx_reg        <= shift_reg[0];
                shift_reg     <= {1'b1, shift_reg[8:1]};
                bits_left_reg <= bits_left_reg - 4'd1;
            end
        end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
        end
    end

    assign busy = busy_reg;
    assign tx   = tx_reg;

endmodule

// File: rtl/msg_tx.sv
// Message transmitter: sends a buffered byte string over UART on trigger,
// optionally followed by CR LF.
module msg_tx
    import msg_tx_pkg::*;
#(
    parameter  int CLOCKS_PER_BIT = 868,
    parameter  int DEPTH          = 32,
    parameter  int APPEND_CRLF    = 0,
    localparam int ADDR_W         = $clog2(DEPTH),
    localparam int LEN_W          = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [LEN_W-1:0]  len,
    input  logic              trigger,
    input  logic              abort,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // One extra bit so count + 2 never wraps when count == DEPTH.
    localparam int IDX_W = LEN_W + 1;
    localparam logic [IDX_W-1:0] EXTRA   = (APPEND_CRLF != 0) ? IDX_W'(2) : '0;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    logic [7:0] mem [DEPTH];

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] index_reg, index_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic             abort_reg, abort_next;

    logic             send;
    logic [7:0]       char_data;
    logic             char_busy;
    logic [IDX_W-1:0] total;
    logic             accept;

    assign busy   = (state_reg != ST_IDLE) && (state_reg != ST_FINISH);
    assign done   = (state_reg == ST_FINISH);
    assign total  = {1'b0, count_reg} + EXTRA;
    assign accept = trigger && ((len != '0) || (APPEND_CRLF != 0));

    // Buffer write port; frozen while a message is in flight.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && ({1'b0, wr_addr} < DEPTH_L)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Character select: message bytes, then CR, then LF.
    always_comb begin
        char_data = LF_BYTE;
        if (index_reg < {1'b0, count_reg}) begin
            char_data = mem[index_reg[ADDR_W-1:0]];
        end else if (index_reg == {1'b0, count_reg}) begin
            char_data = CR_BYTE;
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            count_reg <= '0;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            count_reg <= count_next;
            abort_reg <= abort_next;
        end
    end

    // FSM next state; an abort is remembered and honoured between characters.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        count_next = count_reg;
        abort_next = abort_reg;
        send       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                abort_next = 1'b0;
                if (accept) begin
                    count_next = (len > DEPTH_L) ? DEPTH_L : len;
                    index_next = '0;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                send = 1'b1;
                if (abort) abort_next = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (abort) abort_next = 1'b1;
                if (!char_busy) begin
                    index_next = index_reg + IDX_W'(1);
                    state_next = (abort_reg || abort) ? ST_IDLE : ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (abort_reg || abort) begin
                    state_next = ST_IDLE;
                end else if (index_reg == total) begin
                    state_next = ST_FINISH;
                end else begin
                    state_next = ST_LOAD;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    uart_tx #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .rst  (rst),
        .send (send),
        .data (char_data),
        .busy (char_busy),
        .tx   (tx)
    );

endmodule

// File: tb/tb_msg_tx.sv
// Bench for msg_tx: two instances (without / with CR LF) driven in parallel,
// UART decoders on each tx line checked against queued expected characters.
module tb_msg_tx;

    localparam int CPB    = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 5;
    localparam int HALF   = CPB / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [LEN_W-1:0]  len;
    logic              trigger;
    logic              abort;
    logic              tx0, busy0, done0;
    logic              tx1, busy1, done1;

    int checks   = 0;
    int failures = 0;
    int done_cnt [2];
    int txn      = 0;

    logic [7:0] model_mem [DEPTH];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    msg_tx #(.CLOCKS_PER_BIT(CPB), .DEPTH(DEPTH), .APPEND_CRLF(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .trigger(trigger), .abort(abort),
        .tx(tx0), .busy(busy0), .done(done0)
    );

    msg_tx #(.CLOCKS_PER_BIT(CPB), .DEPTH(DEPTH), .APPEND_CRLF(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .trigger(trigger), .abort(abort),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // UART receive side: one decoder per instance, popping the scoreboard.
    initial begin : decoders
        bit         on   [2];
        int         cnt  [2];
        logic [7:0] rx   [2];
        logic       line;
        logic [7:0] want;
        on[0] = 1'b0;
        on[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                line = (d == 0) ? tx0 : tx1;
                if (rst) begin
                    on[d] = 1'b0;
                end else if (!on[d]) begin
                    if (line == 1'b0) begin
                        on[d]  = 1'b1;
                        cnt[d] = 0;
                    end
                end else begin
                    cnt[d]++;
                    if (cnt[d] == HALF) begin
                        check($sformatf("start_bit_dut%0d", d), {31'd0, line}, 32'd0);
                        if (line != 1'b0) on[d] = 1'b0;
                    end else if (cnt[d] > HALF && cnt[d] < HALF + 9 * CPB &&
                                 (cnt[d] - HALF) % CPB == 0) begin
                        rx[d][(cnt[d] - HALF) / CPB - 1] = line;
                    end else if (cnt[d] == HALF + 9 * CPB) begin
                        on[d] = 1'b0;
                        check($sformatf("stop_bit_dut%0d", d), {31'd0, line}, 32'd1);
                        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_char_dut%0d got=0x%0h want=none", d, rx[d]);
                        end else begin
                            want = (d == 0) ? q0.pop_front() : q1.pop_front();
                            check($sformatf("char_dut%0d", d), {24'd0, rx[d]}, {24'd0, want});
                        end
                    end
                end
            end
        end
    end

    // done pulses: counted, and busy must already be low in the same cycle.
    initial begin : done_mon
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst && done0) begin
                done_cnt[0]++;
                check("busy_in_done_dut0", {31'd0, busy0}, 32'd0);
            end
            if (!rst && done1) begin
                done_cnt[1]++;
                check("busy_in_done_dut1", {31'd0, busy1}, 32'd0);
            end
        end
    end

    task automatic write_byte(input int addr, input logic [7:0] data, input bit apply);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        tick(1);
        wr_en = 1'b0;
        if (apply) model_mem[addr] = data;
    endtask

    // Expected characters: first min(len, DEPTH) buffer bytes, cut to the
    // number of frames allowed to complete; CR LF only on full completion.
    task automatic push_expected(input int l, input int limit);
        int n;
        n = (l > DEPTH) ? DEPTH : l;
        for (int k = 0; k < n && k < limit; k++) begin
            q0.push_back(model_mem[k]);
            q1.push_back(model_mem[k]);
        end
        if (limit >= n) begin
            q1.push_back(8'h0D);
            q1.push_back(8'h0A);
        end
    endtask

    task automatic start_txn(input int l, input int limit, input bit with_abort);
        bit found;
        txn++;
        $display("txn %0d len=%0d limit=%0d abort_with_trigger=%0d", txn, l, limit, with_abort);
        push_expected(l, limit);
        len     = LEN_W'(l);
        trigger = 1'b1;
        abort   = with_abort;
        tick(1);
        trigger = 1'b0;
        abort   = 1'b0;
        len     = '0;
        check("busy_after_accept_dut0", {31'd0, busy0}, (l != 0) ? 32'd1 : 32'd0);
        check("busy_after_accept_dut1", {31'd0, busy1}, 32'd1);
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            if (tx1 == 1'b0) found = 1'b1;
        end
        check("start_latency_dut1", {31'd0, found}, 32'd1);
    endtask

    task automatic finish_txn(input int d0_before, input int d1_before,
                              input int exp_d0, input int exp_d1);
        int guard;
        guard = 0;
        while ((busy0 || busy1) && guard < 3000) begin
            tick(1);
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout got=busy want=idle");
        end
        tick(60);
        check("busy_stays_low_dut0", {31'd0, busy0}, 32'd0);
        check("busy_stays_low_dut1", {31'd0, busy1}, 32'd0);
        check("tx_idle_dut0", {31'd0, tx0}, 32'd1);
        check("tx_idle_dut1", {31'd0, tx1}, 32'd1);
        check("pending_chars_dut0", q0.size(), 32'd0);
        check("pending_chars_dut1", q1.size(), 32'd0);
        check("done_count_dut0", done_cnt[0] - d0_before, exp_d0);
        check("done_count_dut1", done_cnt[1] - d1_before, exp_d1);
        q0.delete();
        q1.delete();
    endtask

    task automatic run_txn(input int l, input bit with_abort);
        int d0, d1;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        start_txn(l, 99, with_abort);
        finish_txn(d0, d1, (l != 0) ? 1 : 0, 1);
    endtask

    initial begin : stimulus
        int d0, d1;
        logic [7:0] b;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len     = '0;
        trigger = 1'b0;
        abort   = 1'b0;
        tick(3);
        check("reset_tx_dut0", {31'd0, tx0}, 32'd1);
        check("reset_tx_dut1", {31'd0, tx1}, 32'd1);
        check("reset_busy_dut0", {31'd0, busy0}, 32'd0);
        check("reset_busy_dut1", {31'd0, busy1}, 32'd0);
        check("reset_done_dut0", {31'd0, done0}, 32'd0);
        rst = 1'b0;
        tick(2);

        for (int a = 0; a < DEPTH; a++) write_byte(a, 8'($urandom), 1'b1);

        // "Hi!"
        write_byte(0, 8'h48, 1'b1);
        write_byte(1, 8'h69, 1'b1);
        write_byte(2, 8'h21, 1'b1);
        run_txn(3, 1'b0);

        // "OK" (second instance appends CR LF)
        write_byte(0, 8'h4F, 1'b1);
        write_byte(1, 8'h4B, 1'b1);
        run_txn(2, 1'b0);

        // Length beyond buffer size is clamped.
        run_txn(20, 1'b0);

        // Abort during the second of five characters.
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        start_txn(5, 2, 1'b0);
        tick(57);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        finish_txn(d0, d1, 0, 0);

        // Trigger and write while busy are ignored; then resend unchanged buffer.
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        start_txn(4, 99, 1'b0);
        tick(20);
        len     = LEN_W'(7);
        trigger = 1'b1;
        b       = ~model_mem[0];
        write_byte(0, b, 1'b0);
        trigger = 1'b0;
        len     = '0;
        finish_txn(d0, d1, 1, 1);
        run_txn(4, 1'b0);

        // Abort in idle does nothing; len=0 trigger sends only CR LF on instance 1.
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(2);
        check("abort_idle_busy_dut0", {31'd0, busy0}, 32'd0);
        run_txn(0, 1'b0);

        // Reset during the first start bit.
        start_txn(6, 0, 1'b0);
        q0.delete();
        q1.delete();
        check("start_bit_before_rst", {31'd0, tx0}, 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_tx_dut0", {31'd0, tx0}, 32'd1);
        check("rst_tx_dut1", {31'd0, tx1}, 32'd1);
        check("rst_busy_dut0", {31'd0, busy0}, 32'd0);
        check("rst_busy_dut1", {31'd0, busy1}, 32'd0);
        tick(2);
        run_txn(6, 1'b0);

        // Randomized messages; first one also raises abort together with trigger.
        for (int r = 0; r < 6; r++) begin
            int nw;
            nw = $urandom_range(1, DEPTH);
            for (int w = 0; w < nw; w++) write_byte($urandom_range(0, DEPTH - 1), 8'($urandom), 1'b1);
            run_txn($urandom_range(1, 20), (r == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case anything stalls.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
